dcache_dm: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the CPU datapath's load/store port and the multi-cycle data memory. Read hits return in the same cycle. Misses and all writes are forwarded to memory using the memory's single-cycle request / `state` busy-flag protocol. The CPU is held with `stall` until the access completes.

---
 rtl/dcache_dm.sv | 166 ++++++++++++++++
 tb/tb_dcache_dm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through no-write-allocate data cache
// Optional hit/miss counters: define DCACHE_STATS_EN.
module dcache_dm #(
    parameter int LINES = 16,
    parameter int TAG_W = 32 - 2 - $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
`ifdef DCACHE_STATS_EN
    input  logic        mem_state,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`else
    input  logic        mem_state
`endif
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sent;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [31:0]        w_line;
    logic               w_fill;
    logic               w_unused;

    assign w_idx    = addr[IDX_W+1:2];
    assign w_tag    = addr[31:IDX_W+2];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line   = r_data[w_idx];
    assign w_fill   = (r_state == S_RD_WAIT) && mem_state;
    assign w_unused = ^addr[1:0];

    assign mem_addr = {addr[31:2], 2'b00};
    assign mem_wd   = wd;

    // r_sent keeps a *_REQ state from mistaking a pre-existing busy for acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sent  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_RD_REQ || r_state == S_WR_REQ) begin
                if (mem_state)
                    r_sent <= 1'b1;
            end else begin
                r_sent <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (MemRead) begin
                    if (!w_hit)
                        w_next = S_RD_REQ;
                end else if (MemWrite) begin
                    w_next = S_WR_REQ;
                end
            end
            S_RD_REQ:  if (r_sent && !mem_state) w_next = S_RD_WAIT;
            S_WR_REQ:  if (r_sent && !mem_state) w_next = S_WR_WAIT;
            S_RD_WAIT: if (mem_state) w_next = S_DONE;
            S_WR_WAIT: if (mem_state) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        rd           = 32'h0;
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemRead) begin
                    stall = !w_hit;
                    if (w_hit)
                        rd = w_line;
                end else begin
                    stall = MemWrite;
                end
            end
            S_RD_REQ: begin
                stall       = 1'b1;
                mem_MemRead = mem_state;
            end
            S_WR_REQ: begin
                stall        = 1'b1;
                mem_MemWrite = mem_state;
            end
            S_RD_WAIT, S_WR_WAIT: stall = 1'b1;
            S_DONE: begin
                if (MemRead)
                    rd = w_line;
            end
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_valid <= '0;
        else if (w_fill)
            r_valid[w_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill) begin
                r_tag[w_idx]  <= w_tag;
                r_data[w_idx] <= mem_rd;
            end else if (r_state == S_IDLE && !MemRead && MemWrite && w_hit) begin
                r_data[w_idx] <= wd;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= 32'h0;
            r_miss_cnt <= 32'h0;
        end else if (r_state == S_IDLE && MemRead) begin
            if (w_hit && r_hit_cnt != 32'hFFFF_FFFF)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            else if (!w_hit && r_miss_cnt != 32'hFFFF_FFFF)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - self-checking bench for dcache_dm with a busy-flag memory model
module tb_dcache_dm;

    localparam int NL = 16;

    logic        clk = 1'b0;
    logic        rst, MemRead, MemWrite;
    logic [31:0] addr, wd, rd;
    logic        stall, mem_MemRead, mem_MemWrite;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_state;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_dm dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .addr         (addr),
        .wd           (wd),
        .rd           (rd),
        .stall        (stall),
        .mem_MemRead  (mem_MemRead),
        .mem_MemWrite (mem_MemWrite),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .mem_state    (mem_state)
`ifdef DCACHE_STATS_EN
        ,.hit_cnt     (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    // data memory: accepts a strobe while free, then stays busy for lat cycles
    logic [31:0] mem [0:255];
    logic [31:0] mem_rd_r;
    int          busy_cnt;
    bit          hold_busy;
    bit          mem_init;
    int          lat;

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] t;
        t = 32'(i);
        if (i == 4)
            return 32'hDEADBEEF;
        return 32'h5A00_0000 ^ (t * 32'h0101_0107);
    endfunction

    assign mem_state = (busy_cnt == 0) && !hold_busy;
    assign mem_rd    = mem_rd_r;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= init_val(i);
            busy_cnt <= 0;
            mem_rd_r <= 32'h0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (mem_state && mem_MemRead) begin
            mem_rd_r <= mem[mem_addr[9:2]];
            busy_cnt <= lat;
        end else if (mem_state && mem_MemWrite) begin
            mem[mem_addr[9:2]] <= mem_wd;
            busy_cnt <= lat;
        end
    end

    // reference model: line -> cached word address, plus the memory image
    logic [31:0] ref_mem [0:255];
    int          line_word [NL];
    int          exp_hits, exp_miss;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++)
            line_word[i] = -1;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic model_read(input int word, output bit hit, output logic [31:0] data);
        hit  = (line_word[word % NL] == word);
        data = ref_mem[word];
        if (hit) begin
            exp_hits++;
        end else begin
            exp_miss++;
            line_word[word % NL] = word;
        end
    endtask

    bit          o_hit, o_timeout;
    logic [31:0] o_rd;
    int          o_nrs, o_nws, o_nstall;

    task automatic do_op(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int b, input int pre);
        int c;
        bit seen, done;
        lat = b; hold_busy = (pre > 0);
        MemRead = r; MemWrite = w; addr = a; wd = d;
        o_hit = 0; o_rd = 0; o_nrs = 0; o_nws = 0; o_nstall = 0; o_timeout = 0;
        seen = 0; done = 0; c = 0;
        while (!done) begin
            @(negedge clk);
            c++;
            if (mem_MemRead || mem_MemWrite) begin
                seen = 1;
                if (mem_MemRead)  o_nrs++;
                if (mem_MemWrite) o_nws++;
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("strobe_while_busy", 32'(mem_state), 32'd1);
                if (mem_MemWrite)
                    chk("mem_wd", mem_wd, d);
            end
            if (seen && stall)
                o_nstall++;
            if (!stall) begin
                o_hit = (c == 1);
                o_rd  = rd;
                done  = 1;
            end else if (c > 200) begin
                o_timeout = 1;
                done = 1;
            end else if (c == pre) begin
                @(posedge clk);
                #1 hold_busy = 0;
            end
        end
        @(posedge clk);
        #1;
        MemRead = 0; MemWrite = 0; hold_busy = 0;
    endtask

    task automatic run_op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int b, input int pre, output bit e_hit, output logic [31:0] e_rd);
        int word;
        word = int'(a[9:2]);
        do_op(r, w, a, d, b, pre);
        e_hit = 0;
        e_rd  = 32'h0;
        if (r) begin
            model_read(word, e_hit, e_rd);
            chk("hit", 32'(o_hit), 32'(e_hit));
            chk("rd", o_rd, e_rd);
            chk("rd_strobes", 32'(o_nrs), e_hit ? 32'd0 : 32'd1);
            chk("wr_strobes", 32'(o_nws), 32'd0);
            if (!e_hit)
                chk("miss_stall_cycles", 32'(o_nstall), 32'(b + 2));
        end else if (w) begin
            ref_mem[word] = d;
            chk("write_stalls", 32'(o_hit), 32'd0);
            chk("wr_strobes", 32'(o_nws), 32'd1);
            chk("rd_strobes", 32'(o_nrs), 32'd0);
            chk("write_stall_cycles", 32'(o_nstall), 32'(b + 2));
        end
        chk("timeout", 32'(o_timeout), 32'd0);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          b;
        int          pre;
        bit          exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    bit          e_hit;
    logic [31:0] e_rd;
    int          guard;

    initial begin
        vecs.push_back('{1, 0, 32'h10, 32'h0,         3, 0, 0, 32'hDEADBEEF});
        vecs.push_back('{1, 0, 32'h10, 32'h0,         1, 0, 1, 32'hDEADBEEF});
        vecs.push_back('{0, 1, 32'h10, 32'h12345678,  2, 0, 0, 32'h0});
        vecs.push_back('{1, 0, 32'h10, 32'h0,         1, 0, 1, 32'h12345678});
        vecs.push_back('{0, 1, 32'h50, 32'hA5A5A5A5,  4, 0, 0, 32'h0});
        vecs.push_back('{1, 0, 32'h10, 32'h0,         1, 0, 1, 32'h12345678});
        vecs.push_back('{1, 0, 32'h50, 32'h0,         1, 0, 0, 32'hA5A5A5A5});
        vecs.push_back('{1, 0, 32'h10, 32'h0,         2, 0, 0, 32'h12345678});
        vecs.push_back('{1, 1, 32'h10, 32'hFFFFFFFF,  1, 0, 1, 32'h12345678});
        vecs.push_back('{1, 0, 32'h10, 32'h0,         1, 0, 1, 32'h12345678});
        vecs.push_back('{1, 0, 32'h13, 32'h0,         1, 0, 1, 32'h12345678});
        vecs.push_back('{0, 1, 32'h24, 32'hCAFEF00D,  2, 2, 0, 32'h0});
        vecs.push_back('{1, 0, 32'h28, 32'h0,         3, 3, 0, init_val(10)});

        rst = 1; mem_init = 1; MemRead = 0; MemWrite = 0;
        addr = 0; wd = 0; lat = 1; hold_busy = 0;
        for (int i = 0; i < 256; i++)
            ref_mem[i] = init_val(i);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0; mem_init = 0;

        @(negedge clk);
        chk("reset_rd", rd, 32'h0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_mem_rd", 32'(mem_MemRead), 32'd0);
        chk("reset_mem_wr", 32'(mem_MemWrite), 32'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].pre, e_hit, e_rd);
            chk("vec_hit", 32'(o_hit), 32'(vecs[i].exp_hit));
            if (vecs[i].r)
                chk("vec_rd", o_rd, vecs[i].exp_rd);
        end

        // reset while a read of 0x24 sits in RD_WAIT
        MemRead = 1; addr = 32'h24; lat = 5;
        guard = 0;
        while (!mem_MemRead && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_test_strobe_seen", 32'(mem_MemRead), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1; MemRead = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_mem_rd", 32'(mem_MemRead), 32'd0);
        chk("rst_mid_mem_wr", 32'(mem_MemWrite), 32'd0);
        guard = 0;
        while (!mem_state && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("mem_free_after_rst", 32'(mem_state), 32'd1);
        @(posedge clk);
        #1;
        model_reset();
        run_op(1, 0, 32'h10, 32'h0, 2, 0, e_hit, e_rd);
        chk("after_rst_0x10_misses", 32'(o_hit), 32'd0);
        run_op(1, 0, 32'h24, 32'h0, 1, 0, e_hit, e_rd);
        chk("after_rst_0x24_misses", 32'(o_hit), 32'd0);

        for (int k = 0; k < 80; k++) begin
            int          word, kind;
            logic [31:0] a;
            word = $urandom_range(0, 47);
            kind = $urandom_range(0, 19);
            a    = (32'(word) << 2) | 32'($urandom_range(0, 3));
            run_op(kind < 10 || kind >= 17, kind >= 10, a, $urandom,
                   $urandom_range(1, 4), $urandom_range(0, 2), e_hit, e_rd);
        end

`ifdef DCACHE_STATS_EN
        @(negedge clk);
        chk("hit_cnt", hit_cnt, 32'(exp_hits));
        chk("miss_cnt", miss_cnt, 32'(exp_miss));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
